bus_bridge_slave: RTL
=====================

Name: bus_bridge_slave

Overview:
Serial-bus slave that forwards bus transactions to a remote board over UART; it is the far-end counterpart of the UART-fed bus bridge master.
- Accepts bit-serial address/data/mode from the bus and packs them into a UART frame {mode, data, addr}.
- For reads, it waits for the remote board's UART reply byte and shifts it back onto the bus.
- Sits on the system bus as an ordinary slave behind the address decoder.

Parameters:
ADDR_WIDTH, 12, slave-local address bits received serially from the bus
DATA_WIDTH, 8, bus data word width
UART_CLOCKS_PER_PULSE, 5208, clocks per UART bit, passed to uart instance
RD_TIMEOUT, 1000000, max clocks to wait for a UART read reply

Ports:
clk  in  1  system clock
rstn  in  1  asynchronous active-low reset
swdata  in  1  serial write data/address from master, LSB first
smode  in  1  0 read, 1 write; sampled on first mvalid cycle
mvalid  in  1  swdata valid qualifier
srdata  out  1  serial read data to master, LSB first
svalid  out  1  srdata valid qualifier
sready  out  1  slave idle, able to accept a transaction
u_tx  out  1  UART transmit line to remote board
u_rx  in  1  UART receive line from remote board
rd_timeout  out  1  one-cycle pulse when a read reply times out

Behaviour:
- Reset values: srdata=0, svalid=0, sready=1, rd_timeout=0. The FSM goes to IDLE and all shift registers and counters clear. Reset is asynchronous, so it takes effect mid-transaction with no cleanup.
- UART instance: codebase uart, TX_DATA_WIDTH = 1+DATA_WIDTH+ADDR_WIDTH, RX_DATA_WIDTH = DATA_WIDTH.
- Frame packing: frame[ADDR_WIDTH-1:0]=addr, next DATA_WIDTH bits=data, MSB=mode. Read frames carry data=0.
- FSM states: IDLE, ADDR, WDATA, TX_REQ, TX_WAIT, RX_WAIT, RDATA.
- IDLE: sready=1.
  - On mvalid=1, latch smode, shift in bit 0 of addr, deassert sready next cycle, go to ADDR with bit count 1.
  - If ADDR_WIDTH==1, skip directly to the ADDR exit condition.
- ADDR: on each mvalid=1 cycle, shift swdata into addr[count] and increment count.
  - mvalid=0 cycles are stalls; hold state.
  - After ADDR_WIDTH bits: go to WDATA if mode=1, else to TX_REQ.
- WDATA: shift DATA_WIDTH bits the same way, with the same stall rule, then go to TX_REQ.
- TX_REQ: only enter when uart tx_busy=0; otherwise hold. Pulse data_en for exactly one clock with the packed frame, then go to TX_WAIT.
- TX_WAIT: wait until tx_busy has risen and then fallen.
  - Write: go to IDLE. The write completes when the frame is fully sent; sready returns to 1 the cycle after.
  - Read: clear the timeout counter and go to RX_WAIT.
- RX_WAIT: detect a rising edge of uart ready via a registered previous value.
  - On the edge, latch data_output and go to RDATA.
  - The counter increments every cycle. When it reaches RD_TIMEOUT, latch data = all ones, pulse rd_timeout for 1 cycle, and go to RDATA.
  - An edge and the timeout in the same cycle: the edge wins and rd_timeout does not pulse.
- RDATA: for DATA_WIDTH consecutive cycles, drive svalid=1 with srdata = data[i], i = 0 upward. Then drop svalid and srdata to 0 and go to IDLE.
- UART ready edges outside RX_WAIT are ignored: no latch and no effect.
- mvalid while sready=0 and not in ADDR/WDATA is ignored. The master must observe sready before starting.

Test Plan:
- Write: reset, then send addr=0x5A3, data=0xC6, mode=1 serially. A UART decoder on u_tx captures frame {1,0xC6,0x5A3}; sready=0 until the frame completes, then 1.
- Read: send addr=0x012, mode=0. The frame captured is {0,0x00,0x012}. Drive reply 0x3C on u_rx; svalid is high 8 cycles with srdata sequence 0,0,1,1,1,1,0,0.
- Stalled shifting: insert mvalid=0 gaps of 1-3 cycles randomly during address and data of a write addr=0xFFF, data=0x01. The captured frame is unchanged, {1,0x01,0xFFF}.
- Timeout: with RD_TIMEOUT=200, read addr=0x100 with no reply. rd_timeout pulses once at 200 cycles after TX completion; srdata shifts out 0xFF; then sready=1.
- Spurious RX: drive a UART byte 0x77 while IDLE, then perform a read with reply 0x21. The returned data is 0x21, not 0x77.
- Reset mid-read: assert rstn=0 during RX_WAIT. Outputs return to reset values immediately (asynchronous). After release, a new write addr=0x001, data=0x55 completes normally.

Source files
------------

// File: rtl/bus_bridge_slave.sv
// Bus slave that forwards serial bus transactions to a remote board over UART.
// Read replies come back as one UART byte and are shifted onto the bus LSB first.
module uart #(
    parameter int CLOCKS_PER_PULSE = 5208,
    parameter int TX_DATA_WIDTH    = 8,
    parameter int RX_DATA_WIDTH    = 8
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic [TX_DATA_WIDTH-1:0] data_input,
    input  logic                     data_en,
    output logic                     tx,
    output logic                     tx_busy,
    input  logic                     rx,
    output logic                     ready,
    output logic [RX_DATA_WIDTH-1:0] data_output
);
    localparam int KW = $clog2(CLOCKS_PER_PULSE + 1);
    localparam int LW = $clog2(TX_DATA_WIDTH + 2);
    localparam int BW = $clog2(RX_DATA_WIDTH + 1);
    localparam logic [KW-1:0] K_LAST = KW'(CLOCKS_PER_PULSE - 1);
    localparam logic [KW-1:0] K_HALF = KW'(CLOCKS_PER_PULSE / 2);
    localparam logic [BW-1:0] B_LAST = BW'(RX_DATA_WIDTH - 1);

    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;

    logic                     r_tx;
    logic                     r_tx_busy;
    logic [KW-1:0]            r_tx_clk;
    logic [LW-1:0]            r_tx_left;
    logic [TX_DATA_WIDTH:0]   r_tx_sh;
    rx_state_t                r_rx_st;
    logic                     r_rx_s1;
    logic                     r_rx_s2;
    logic [KW-1:0]            r_rx_clk;
    logic [BW-1:0]            r_rx_bit;
    logic [RX_DATA_WIDTH-1:0] r_rx_sh;
    logic [RX_DATA_WIDTH-1:0] r_rx_data;
    logic                     r_ready;

    // Start bit, data LSB first, then one stop bit.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_tx      <= 1'b1;
            r_tx_busy <= 1'b0;
            r_tx_clk  <= '0;
            r_tx_left <= '0;
            r_tx_sh   <= '0;
        end else if (!r_tx_busy) begin
            if (data_en) begin
                r_tx      <= 1'b0;
                r_tx_sh   <= {1'b1, data_input};
                r_tx_left <= LW'(TX_DATA_WIDTH + 1);
                r_tx_clk  <= '0;
                r_tx_busy <= 1'b1;
            end
        end else if (r_tx_clk != K_LAST) begin
            r_tx_clk <= r_tx_clk + 1'b1;
        end else begin
            r_tx_clk <= '0;
            if (r_tx_left == '0) begin
                r_tx_busy <= 1'b0;
                r_tx      <= 1'b1;
            end else begin
                r_tx      <= r_tx_sh[0];
                r_tx_sh   <= r_tx_sh >> 1;
                r_tx_left <= r_tx_left - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rx_st   <= R_IDLE;
            r_rx_s1   <= 1'b1;
            r_rx_s2   <= 1'b1;
            r_rx_clk  <= '0;
            r_rx_bit  <= '0;
            r_rx_sh   <= '0;
            r_rx_data <= '0;
            r_ready   <= 1'b0;
        end else begin
            r_rx_s1 <= rx;
            r_rx_s2 <= r_rx_s1;
            unique case (r_rx_st)
                R_IDLE: begin
                    if (!r_rx_s2) begin
                        r_rx_st  <= R_START;
                        r_rx_clk <= '0;
                        r_ready  <= 1'b0;
                    end
                end
                R_START: begin
                    if (r_rx_clk == K_HALF) begin
                        r_rx_clk <= '0;
                        r_rx_bit <= '0;
                        r_rx_st  <= r_rx_s2 ? R_IDLE : R_DATA;
                    end else begin
                        r_rx_clk <= r_rx_clk + 1'b1;
                    end
                end
                R_DATA: begin
                    if (r_rx_clk == K_LAST) begin
                        r_rx_clk <= '0;
                        r_rx_sh  <= {r_rx_s2, r_rx_sh[RX_DATA_WIDTH-1:1]};
                        if (r_rx_bit == B_LAST) r_rx_st <= R_STOP;
                        else r_rx_bit <= r_rx_bit + 1'b1;
                    end else begin
                        r_rx_clk <= r_rx_clk + 1'b1;
                    end
                end
                R_STOP: begin
                    if (r_rx_clk == K_LAST) begin
                        r_rx_clk  <= '0;
                        r_rx_st   <= R_IDLE;
                        r_rx_data <= r_rx_sh;
                        r_ready   <= 1'b1;
                    end else begin
                        r_rx_clk <= r_rx_clk + 1'b1;
                    end
                end
                default: r_rx_st <= R_IDLE;
            endcase
        end
    end

    assign tx          = r_tx;
    assign tx_busy     = r_tx_busy;
    assign ready       = r_ready;
    assign data_output = r_rx_data;
endmodule

module bus_bridge_slave #(
    parameter int ADDR_WIDTH            = 12,
    parameter int DATA_WIDTH            = 8,
    parameter int UART_CLOCKS_PER_PULSE = 5208,
    parameter int RD_TIMEOUT            = 1000000
) (
    input  logic clk,
    input  logic rstn,
    input  logic swdata,
    input  logic smode,
    input  logic mvalid,
    output logic srdata,
    output logic svalid,
    output logic sready,
    output logic u_tx,
    input  logic u_rx,
    output logic rd_timeout
);
    localparam int FW   = 1 + DATA_WIDTH + ADDR_WIDTH;
    localparam int MAXW = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
    localparam int CW   = $clog2(MAXW + 1);
    localparam int TW   = $clog2(RD_TIMEOUT + 1);
    localparam logic [CW-1:0] A_LAST = CW'(ADDR_WIDTH - 1);
    localparam logic [CW-1:0] D_LAST = CW'(DATA_WIDTH - 1);
    localparam logic [CW-1:0] D_END  = CW'(DATA_WIDTH);
    localparam logic [TW-1:0] T_LAST = TW'(RD_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_WDATA, S_TX_REQ, S_TX_WAIT, S_RX_WAIT, S_RDATA
    } state_t;

    state_t                r_state;
    logic                  r_mode;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_data;
    logic [CW-1:0]         r_cnt;
    logic [TW-1:0]         r_tmo;
    logic                  r_seen;
    logic                  r_rdy_q;
    logic                  r_data_en;
    logic [FW-1:0]         r_frame;
    logic                  r_sready;
    logic                  r_svalid;
    logic                  r_srdata;
    logic                  r_rd_timeout;

    logic                  w_tx_busy;
    logic                  w_rx_ready;
    logic [DATA_WIDTH-1:0] w_rx_data;
    logic [ADDR_WIDTH-1:0] w_addr_sh;
    logic [DATA_WIDTH-1:0] w_data_sh;
    logic                  w_rdy_edge;

    uart #(
        .CLOCKS_PER_PULSE(UART_CLOCKS_PER_PULSE),
        .TX_DATA_WIDTH   (FW),
        .RX_DATA_WIDTH   (DATA_WIDTH)
    ) u_uart (
        .clk        (clk),
        .rstn       (rstn),
        .data_input (r_frame),
        .data_en    (r_data_en),
        .tx         (u_tx),
        .tx_busy    (w_tx_busy),
        .rx         (u_rx),
        .ready      (w_rx_ready),
        .data_output(w_rx_data)
    );

    // Serial bits arrive LSB first, so shift in from the top.
    always_comb begin
        w_addr_sh = r_addr >> 1;
        w_addr_sh[ADDR_WIDTH-1] = swdata;
        w_data_sh = r_data >> 1;
        w_data_sh[DATA_WIDTH-1] = swdata;
    end

    assign w_rdy_edge = w_rx_ready & ~r_rdy_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state      <= S_IDLE;
            r_mode       <= 1'b0;
            r_addr       <= '0;
            r_data       <= '0;
            r_cnt        <= '0;
            r_tmo        <= '0;
            r_seen       <= 1'b0;
            r_rdy_q      <= 1'b0;
            r_data_en    <= 1'b0;
            r_frame      <= '0;
            r_sready     <= 1'b1;
            r_svalid     <= 1'b0;
            r_srdata     <= 1'b0;
            r_rd_timeout <= 1'b0;
        end else begin
            r_data_en    <= 1'b0;
            r_rd_timeout <= 1'b0;
            r_rdy_q      <= w_rx_ready;
            unique case (r_state)
                S_IDLE: begin
                    if (mvalid) begin
                        r_mode   <= smode;
                        r_addr   <= w_addr_sh;
                        r_sready <= 1'b0;
                        if (ADDR_WIDTH == 1) begin
                            r_cnt   <= '0;
                            r_state <= smode ? S_WDATA : S_TX_REQ;
                        end else begin
                            r_cnt   <= CW'(1);
                            r_state <= S_ADDR;
                        end
                    end
                end
                S_ADDR: begin
                    if (mvalid) begin
                        r_addr <= w_addr_sh;
                        if (r_cnt == A_LAST) begin
                            r_cnt   <= '0;
                            r_state <= r_mode ? S_WDATA : S_TX_REQ;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                S_WDATA: begin
                    if (mvalid) begin
                        r_data <= w_data_sh;
                        if (r_cnt == D_LAST) begin
                            r_cnt   <= '0;
                            r_state <= S_TX_REQ;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                S_TX_REQ: begin
                    if (!w_tx_busy) begin
                        r_frame   <= {r_mode, r_mode ? r_data : '0, r_addr};
                        r_data_en <= 1'b1;
                        r_seen    <= 1'b0;
                        r_state   <= S_TX_WAIT;
                    end
                end
                S_TX_WAIT: begin
                    if (w_tx_busy) begin
                        r_seen <= 1'b1;
                    end else if (r_seen) begin
                        if (r_mode) begin
                            r_sready <= 1'b1;
                            r_state  <= S_IDLE;
                        end else begin
                            r_tmo   <= '0;
                            r_state <= S_RX_WAIT;
                        end
                    end
                end
                S_RX_WAIT: begin
                    // A reply edge beats a simultaneous timeout.
                    if (w_rdy_edge) begin
                        r_svalid <= 1'b1;
                        r_srdata <= w_rx_data[0];
                        r_data   <= w_rx_data >> 1;
                        r_cnt    <= CW'(1);
                        r_state  <= S_RDATA;
                    end else if (r_tmo == T_LAST) begin
                        r_rd_timeout <= 1'b1;
                        r_svalid     <= 1'b1;
                        r_srdata     <= 1'b1;
                        r_data       <= '1;
                        r_cnt        <= CW'(1);
                        r_state      <= S_RDATA;
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                    end
                end
                S_RDATA: begin
                    if (r_cnt == D_END) begin
                        r_svalid <= 1'b0;
                        r_srdata <= 1'b0;
                        r_sready <= 1'b1;
                        r_cnt    <= '0;
                        r_state  <= S_IDLE;
                    end else begin
                        r_srdata <= r_data[0];
                        r_data   <= r_data >> 1;
                        r_cnt    <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign srdata     = r_srdata;
    assign svalid     = r_svalid;
    assign sready     = r_sready;
    assign rd_timeout = r_rd_timeout;
endmodule
